// File: rtl/usb_fifo_write_arbiter.sv
// Frame-granular round-robin arbiter sharing the USB external FIFO write port among NUM_REQ producers.
// A grant covers one whole frame; the owner's words reach the FIFO one cycle later; stalled owners time out.
module usb_fifo_write_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   Clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     Req,
  input  logic [16*NUM_REQ-1:0]  Data_In,
  input  logic [NUM_REQ-1:0]     Data_In_Enable,
  input  logic [NUM_REQ-1:0]     Frame_End,
  output logic [NUM_REQ-1:0]     Grant,
  output logic [NUM_REQ-1:0]     Fifo_Full_Out,
  input  logic                   ExternalDataFifoFull,
  output logic [15:0]            ExternalDataFifo_din,
  output logic                   ExternalDataFifo_wr,
  output logic                   Timeout_Pulse,
  output logic                   Overflow_Error
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWNED   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t               r_state, w_state_next;
  logic [NUM_REQ-1:0]   r_grant, w_grant_next;
  logic [IDX_W-1:0]     r_last, w_last_next;
  logic [15:0]          r_idle, w_idle_next;
  logic [15:0]          r_din, w_din_next;
  logic                 r_wr, w_wr_next;
  logic                 r_pulse, w_pulse_next;
  logic                 r_ovf, w_ovf_next;

  logic [15:0]          w_lane [NUM_REQ];
  logic [15:0]          w_own_data;
  logic                 w_own_en;
  logic                 w_own_fe;
  logic                 w_own_req;
  logic [15:0]          w_idle_inc;
  logic                 w_pick_valid;
  logic [IDX_W-1:0]     w_pick_idx;
  logic [IDX_W-1:0]     w_cand;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign w_lane[gi]        = Data_In[16*gi +: 16];
      // Non-owners are told the FIFO is full so they hold in their wait states.
      assign Fifo_Full_Out[gi] = r_grant[gi] ? ExternalDataFifoFull : 1'b1;
    end
  endgenerate

  // While OWNED, r_last is the current owner's index.
  assign w_own_data = w_lane[r_last];
  assign w_own_en   = Data_In_Enable[r_last];
  assign w_own_fe   = Frame_End[r_last];
  assign w_own_req  = Req[r_last];
  assign w_idle_inc = (r_idle == 16'hFFFF) ? r_idle : r_idle + 16'd1;

  // Round-robin search starting just after the previous owner; the nearest set request wins.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_idx   = r_last;
    w_cand       = r_last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDX_W'((int'(r_last) + k) % NUM_REQ);
      if (!w_pick_valid && Req[w_cand]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_last_next  = r_last;
    w_idle_next  = r_idle;
    w_din_next   = r_din;
    w_wr_next    = 1'b0;
    w_pulse_next = 1'b0;
    w_ovf_next   = r_ovf;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) begin
          w_grant_next = ONE_HOT_0 << w_pick_idx;
          w_last_next  = w_pick_idx;
          w_idle_next  = 16'd0;
          w_state_next = S_OWNED;
        end
      end
      S_OWNED: begin
        w_din_next = w_own_data;
        if (w_own_en) begin
          w_idle_next = 16'd0;
          // A word offered while the FIFO is full is lost; remember it until reset.
          if (ExternalDataFifoFull) begin
            w_ovf_next = 1'b1;
          end else begin
            w_wr_next = 1'b1;
          end
          if (w_own_fe) begin
            w_state_next = S_RELEASE;
          end
        end else begin
          w_idle_next = w_idle_inc;
          if (w_idle_inc == TIMEOUT_LIMIT) begin
            w_pulse_next = 1'b1;
            w_state_next = S_RELEASE;
          end
          if (!w_own_req) begin
            w_state_next = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        w_grant_next = '0;
        w_state_next = S_IDLE;
      end
      default: begin
        w_grant_next = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= IDX_W'(NUM_REQ - 1);
      r_idle  <= 16'd0;
      r_din   <= 16'd0;
      r_wr    <= 1'b0;
      r_pulse <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_last  <= w_last_next;
      r_idle  <= w_idle_next;
      r_din   <= w_din_next;
      r_wr    <= w_wr_next;
      r_pulse <= w_pulse_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign Grant                = r_grant;
  assign ExternalDataFifo_din = r_din;
  assign ExternalDataFifo_wr  = r_wr;
  assign Timeout_Pulse        = r_pulse;
  assign Overflow_Error       = r_ovf;

endmodule

// File: tb/tb_usb_fifo_write_arbiter.sv
// Bench for usb_fifo_write_arbiter: frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations on grant order and FIFO contents.
module tb_usb_fifo_write_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic              Clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   Req = '0;
  logic [16*NREQ-1:0] Data_In = '0;
  logic [NREQ-1:0]   Data_In_Enable = '0;
  logic [NREQ-1:0]   Frame_End = '0;
  logic [NREQ-1:0]   Grant;
  logic [NREQ-1:0]   Fifo_Full_Out;
  logic              ExternalDataFifoFull = 1'b0;
  logic [15:0]       ExternalDataFifo_din;
  logic              ExternalDataFifo_wr;
  logic              Timeout_Pulse;
  logic              Overflow_Error;

  usb_fifo_write_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .reset_n(reset_n), .Req(Req), .Data_In(Data_In),
    .Data_In_Enable(Data_In_Enable), .Frame_End(Frame_End), .Grant(Grant),
    .Fifo_Full_Out(Fifo_Full_Out), .ExternalDataFifoFull(ExternalDataFifoFull),
    .ExternalDataFifo_din(ExternalDataFifo_din), .ExternalDataFifo_wr(ExternalDataFifo_wr),
    .Timeout_Pulse(Timeout_Pulse), .Overflow_Error(Overflow_Error)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] fifo_log [$];
  int          grant_log [$];
  logic [15:0] exp_q [$];
  int          g_exp [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string name);
    chk({name, " word count"}, 32'(fifo_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s word %0d", name, i),
          (i < fifo_log.size()) ? {16'h0, fifo_log[i]} : 32'hFFFF_FFFF, {16'h0, exp_q[i]});
  endtask

  // Frame-level reference: who owns the port, whether the frame is closing, and the owner's silence.
  int          m_own = -1;
  bit          m_closing = 1'b0;
  int          m_prev = NREQ - 1;
  int          m_silent = 0;
  bit          m_wr = 1'b0;
  logic [15:0] m_din = 16'h0;
  bit          m_pulse = 1'b0;
  bit          m_ovf = 1'b0;
  bit          m_found;
  int          m_c;

  always @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      m_own = -1; m_closing = 0; m_prev = NREQ - 1; m_silent = 0;
      m_wr = 0; m_din = 16'h0; m_pulse = 0; m_ovf = 0;
    end else begin
      m_pulse = 0;
      m_wr = 0;
      if (m_own < 0) begin
        m_found = 0;
        for (int k = 1; k <= NREQ; k++) begin
          m_c = (m_prev + k) % NREQ;
          if (!m_found && Req[m_c]) begin
            m_found = 1; m_own = m_c; m_prev = m_c; m_silent = 0; m_closing = 0;
          end
        end
      end else if (m_closing) begin
        m_own = -1;
      end else if (Data_In_Enable[m_own]) begin
        m_silent = 0;
        if (ExternalDataFifoFull) m_ovf = 1;
        else begin m_wr = 1; m_din = Data_In[16*m_own +: 16]; end
        if (Frame_End[m_own]) m_closing = 1;
      end else begin
        if (m_silent < 65535) m_silent++;
        if (m_silent == TO) begin m_pulse = 1; m_closing = 1; end
        if (!Req[m_own]) m_closing = 1;
      end
    end
  end

  logic [NREQ-1:0] prev_grant = '0;
  logic [NREQ-1:0] e_grant, e_ffo;
  always @(negedge Clk) begin
    e_grant = (m_own >= 0) ? NREQ'(1 << m_own) : '0;
    for (int i = 0; i < NREQ; i++) e_ffo[i] = (m_own == i) ? ExternalDataFifoFull : 1'b1;
    chk("cyc Grant", 32'(Grant), 32'(e_grant));
    chk("cyc wr", 32'(ExternalDataFifo_wr), 32'(m_wr));
    if (m_wr) chk("cyc din", 32'(ExternalDataFifo_din), 32'(m_din));
    chk("cyc Timeout_Pulse", 32'(Timeout_Pulse), 32'(m_pulse));
    chk("cyc Overflow_Error", 32'(Overflow_Error), 32'(m_ovf));
    chk("cyc Fifo_Full_Out", 32'(Fifo_Full_Out), 32'(e_ffo));
    if (ExternalDataFifo_wr) fifo_log.push_back(ExternalDataFifo_din);
    if (Grant != 0 && prev_grant == 0)
      for (int i = 0; i < NREQ; i++) if (Grant[i]) grant_log.push_back(i);
    prev_grant = Grant;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int r, input logic [15:0] w, input logic last);
    Data_In_Enable = NREQ'(1 << r);
    Data_In[16*r +: 16] = w;
    Frame_End = last ? NREQ'(1 << r) : '0;
    tick();
    Data_In_Enable = '0;
    Frame_End = '0;
  endtask

  task automatic wait_release();
    int n = 0;
    while (Grant != 0 && n < 64) begin tick(); n++; end
    if (Grant != 0) begin
      n_vec++; n_bad++;
      $display("FAIL release wait: Grant=%0h still set after 64 cycles, required 0", Grant);
    end
  endtask

  task automatic wait_grant(output int o);
    int n = 0;
    o = 0;
    while (Grant == 0 && n < 64) begin tick(); n++; end
    if (Grant == 0) begin
      n_vec++; n_bad++;
      $display("FAIL grant wait: Grant=0 after 64 cycles, required a grant");
    end
    for (int i = 0; i < NREQ; i++) if (Grant[i]) o = i;
  endtask

  task automatic pulse_reset();
    Req = '0; Data_In_Enable = '0; Frame_End = '0; ExternalDataFifoFull = 1'b0;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  int o, cnt;

  initial begin
    // Reset state
    tick(); tick(); tick();
    chk("rst Grant", 32'(Grant), 32'h0);
    chk("rst wr", 32'(ExternalDataFifo_wr), 32'h0);
    chk("rst din", 32'(ExternalDataFifo_din), 32'h0);
    chk("rst Timeout_Pulse", 32'(Timeout_Pulse), 32'h0);
    chk("rst Overflow_Error", 32'(Overflow_Error), 32'h0);
    chk("rst Fifo_Full_Out", 32'(Fifo_Full_Out), 32'hF);
    reset_n = 1'b1;
    tick();

    // 1: single frame from R0
    fifo_log.delete();
    Req = 4'b0001;
    tick();
    chk("t1 Grant after Req", 32'(Grant), 32'h1);
    send(0, 16'h5343, 1'b0);
    chk("t1 first word latency", {31'h0, ExternalDataFifo_wr}, 32'h1);
    send(0, 16'h43FF, 1'b0);
    send(0, 16'hFF45, 1'b1);
    Req = '0;
    chk("t1 Grant on tail", 32'(Grant), 32'h1);
    chk("t1 tail din", 32'(ExternalDataFifo_din), 32'hFF45);
    tick();
    chk("t1 Grant after tail", 32'(Grant), 32'h0);
    tick();
    exp_q = '{16'h5343, 16'h43FF, 16'hFF45};
    chk_log("t1");

    // 2: all four requesting, two-word frames, round-robin from reset
    pulse_reset();
    fifo_log.delete(); grant_log.delete();
    Req = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      wait_release();
      wait_grant(o);
      send(o, {4'hA, 4'(o), 4'(f), 4'h0}, 1'b0);
      send(o, {4'hA, 4'(o), 4'(f), 4'h1}, 1'b1);
      if (f == 4) Req = '0;
    end
    wait_release();
    tick();
    chk("t2 grant count", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t2 grant order %0d", i),
          (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(g_exp[i]));
    exp_q = '{16'hA000, 16'hA001, 16'hA110, 16'hA111, 16'hA220,
              16'hA221, 16'hA330, 16'hA331, 16'hA040, 16'hA041};
    chk_log("t2");

    // 3: FIFO full while R1 owns
    fifo_log.delete();
    Req = 4'b0010;
    wait_grant(o);
    chk("t3 owner", 32'(Grant), 32'h2);
    ExternalDataFifoFull = 1'b1;
    #1;
    chk("t3 Fifo_Full_Out full", 32'(Fifo_Full_Out), 32'hF);
    send(1, 16'hBAD1, 1'b0);
    chk("t3 wr while full", {31'h0, ExternalDataFifo_wr}, 32'h0);
    chk("t3 Overflow_Error", {31'h0, Overflow_Error}, 32'h1);
    ExternalDataFifoFull = 1'b0;
    #1;
    chk("t3 Fifo_Full_Out free", 32'(Fifo_Full_Out), 32'hD);
    send(1, 16'h1111, 1'b0);
    send(1, 16'h2222, 1'b1);
    Req = '0;
    tick(); tick();
    exp_q = '{16'h1111, 16'h2222};
    chk_log("t3");

    // 4: R2 granted and silent, R3 pending
    Req = 4'b1100;
    wait_grant(o);
    chk("t4 owner", 32'(Grant), 32'h4);
    cnt = 0;
    while (!Timeout_Pulse && cnt < 40) begin tick(); cnt++; end
    chk("t4 timeout latency", 32'(cnt), 32'd16);
    chk("t4 Grant at pulse", 32'(Grant), 32'h4);
    Req = 4'b1000;
    tick();
    chk("t4 pulse width", {31'h0, Timeout_Pulse}, 32'h0);
    chk("t4 Grant cleared", 32'(Grant), 32'h0);
    tick();
    chk("t4 R3 granted", 32'(Grant), 32'h8);
    send(3, 16'h3333, 1'b1);
    Req = '0;
    tick(); tick();

    // 5: non-owner strobes are ignored
    pulse_reset();
    fifo_log.delete();
    Req = 4'b0001;
    wait_grant(o);
    chk("t5 owner", 32'(Grant), 32'h1);
    Data_In[15:0] = 16'h0505;
    Data_In[47:32] = 16'hDEAD;
    Data_In_Enable = 4'b0101;
    tick();
    Data_In_Enable = 4'b0100;
    tick();
    Data_In_Enable = '0;
    send(0, 16'h0506, 1'b1);
    Req = '0;
    tick(); tick();
    exp_q = '{16'h0505, 16'h0506};
    chk_log("t5");
    chk("t5 Overflow_Error", {31'h0, Overflow_Error}, 32'h0);

    // 6: asynchronous reset mid-frame, then 1001 must go to R0
    Req = 4'b0010;
    wait_grant(o);
    send(1, 16'h6161, 1'b0);
    chk("t6 word before reset", {31'h0, ExternalDataFifo_wr}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6 async Grant", 32'(Grant), 32'h0);
    chk("t6 async wr", {31'h0, ExternalDataFifo_wr}, 32'h0);
    chk("t6 async din", 32'(ExternalDataFifo_din), 32'h0);
    Req = 4'b1001;
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6 R0 first", 32'(Grant), 32'h1);
    send(0, 16'h7777, 1'b1);
    Req = '0;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
